// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I/D cache fill arbiter.
package cache_arb_pkg;

  localparam int          BLK_WORDS = 8;          // words per cache block
  localparam int          MEM_LAT   = 4;          // memory read latency, mem_en to mem_valid
  localparam logic [15:0] BLK_MASK  = 16'hFFF0;   // clears the byte offset within a block

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fill_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/cache_fill_arbiter_word_cnt.sv
// Three-bit word counter with clear, enable and a flag on the last word of a block.
module word_cnt
  import cache_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [2:0] cnt_o,
  output logic       last_o
);

  logic [2:0] cnt_q, cnt_d;

  // Next count: clear wins over enable so a new block always starts at word 0.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (that would infer a latch).
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for state so every flop samples its pre-edge inputs.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == 3'(BLK_WORDS - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the shared main memory between I-cache and D-cache block fills and
// passes D-cache write-through stores to memory whenever no fill is in progress.
module cache_fill_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              i_fill_wen,
  output logic              d_fill_wen,
  output logic [2:0]        fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_tag_wen,
  output logic              d_tag_wen,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              busy
);

  // Block-align mask widened to ADDR_W with all upper bits kept.
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(~BLK_MASK);

  fill_state_t       state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [2:0] issue_cnt, recv_cnt;
  logic       issue_last, recv_last;
  logic       in_fill, fill_beat, recv_done;

  // Returning words are only accepted while a fill owns the memory; the 8th one ends it.
  assign in_fill   = (state_q != IDLE);
  assign fill_beat = in_fill && mem_valid;
  assign recv_done = fill_beat && recv_last;

  word_cnt u_issue_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == IDLE),
    .en_i   (state_q == ISSUE),
    .cnt_o  (issue_cnt),
    .last_o (issue_last)
  );

  word_cnt u_recv_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == IDLE),
    .en_i   (fill_beat),
    .cnt_o  (recv_cnt),
    .last_o (recv_last)
  );

  // State, owner and block base registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  // Next state: a store takes the IDLE cycle, otherwise D misses win over I misses.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (!st_req) begin
          if (d_miss) begin
            state_d = ISSUE;
            owner_d = OWN_D;
            base_d  = d_miss_addr & BASE_MASK;
          end else if (i_miss) begin
            state_d = ISSUE;
            owner_d = OWN_I;
            base_d  = i_miss_addr & BASE_MASK;
          end
        end
      end
      ISSUE: begin
        if (recv_done) begin
          state_d = DONE;
        end else if (issue_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (recv_done) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory requests from state and issue count, fill steering from the owner.
  always_comb begin
    st_ack      = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_fill_wen  = 1'b0;
    d_fill_wen  = 1'b0;
    fill_data   = '0;
    i_tag_wen   = 1'b0;
    d_tag_wen   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (st_req) begin
          st_ack    = 1'b1;
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = st_addr;
          mem_wdata = st_data;
        end
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = base_q + ADDR_W'({issue_cnt, 1'b0});
      end
      DONE: begin
        if (owner_q == OWN_D) begin
          d_tag_wen   = 1'b1;
          d_fill_done = 1'b1;
        end else begin
          i_tag_wen   = 1'b1;
          i_fill_done = 1'b1;
        end
      end
      default: ;
    endcase
    if (fill_beat) begin
      fill_data = mem_rdata;
      if (owner_q == OWN_D) begin
        d_fill_wen = 1'b1;
      end else begin
        i_fill_wen = 1'b1;
      end
    end
  end

  assign fill_word = recv_cnt;
  assign busy      = in_fill;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: a transaction-level model predicts every
// memory read, fill word, completion pulse and store ack; a monitor compares them.
module tb_cache_fill_arbiter;
  import cache_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_miss, d_miss, st_req, mem_valid;
  logic [AW-1:0] i_miss_addr, d_miss_addr, st_addr;
  logic [DW-1:0] st_data, mem_rdata;
  logic          st_ack, mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, fill_data;
  logic          i_fill_wen, d_fill_wen, i_tag_wen, d_tag_wen, i_fill_done, d_fill_done, busy;
  logic [2:0]    fill_word;

  cache_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .st_req      (st_req),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_ack      (st_ack),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .i_fill_wen  (i_fill_wen),
    .d_fill_wen  (d_fill_wen),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .i_tag_wen   (i_tag_wen),
    .d_tag_wen   (d_tag_wen),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [15:0] addr; } rd_t;
  typedef struct { int cyc; bit is_d; logic [2:0] word; logic [15:0] data; } fill_t;
  typedef struct { int cyc; bit is_d; } done_t;
  typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; } st_t;
  typedef struct { int due; logic [15:0] addr; } mem_t;

  rd_t   exp_rd_q[$];
  fill_t exp_fill_q[$];
  done_t exp_done_q[$];
  st_t   exp_st_q[$];
  mem_t  mem_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Requester-side state and model bookkeeping.
  bit          i_r, d_r, st_r, rst_r, rnd_en;
  logic [15:0] i_a, d_a, s_a, s_d;
  bit          i_inflight, d_inflight;
  int          i_drop_at, d_drop_at;
  int          st_ack_at = -10;
  int          free_at   = 0;
  int          busy_lo   = -1;
  int          busy_hi   = -2;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string got, input string want);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d: got %s, want %s", name, cyc, got, want);
  endtask

  // Model of one granted fill: 8 addresses from cycle g+1, data MEM_LAT later, done after the last word.
  task automatic grant(input bit is_d, input logic [15:0] addr);
    logic [15:0] base;
    rd_t         r;
    fill_t       f;
    done_t       d;
    base = {addr[15:4], 4'h0};
    for (int k = 0; k < BLK_WORDS; k++) begin
      r.cyc  = cyc + 1 + k;
      r.addr = base + 16'(2 * k);
      exp_rd_q.push_back(r);
      f.cyc  = cyc + 1 + MEM_LAT + k;
      f.is_d = is_d;
      f.word = 3'(k);
      f.data = mem_fn(base + 16'(2 * k));
      exp_fill_q.push_back(f);
    end
    d.cyc  = cyc + 1 + MEM_LAT + BLK_WORDS;
    d.is_d = is_d;
    exp_done_q.push_back(d);
    busy_lo = cyc + 1;
    busy_hi = d.cyc;
    free_at = d.cyc + 1;
    if (is_d) begin
      d_inflight = 1'b1;
      d_drop_at  = free_at;
    end else begin
      i_inflight = 1'b1;
      i_drop_at  = free_at;
    end
  endtask

  task automatic random_stim();
    if (!st_r && $urandom_range(0, 11) == 0) begin
      st_r = 1'b1;
      s_a  = 16'($urandom);
      s_d  = 16'($urandom);
    end
    if (!d_r && !d_inflight && $urandom_range(0, 15) == 0) begin
      d_r = 1'b1;
      d_a = 16'($urandom);
    end
    if (!i_r && !i_inflight && $urandom_range(0, 15) == 0) begin
      i_r = 1'b1;
      i_a = 16'($urandom);
    end
    if (i_r && i_inflight && $urandom_range(0, 39) == 0) i_r = 1'b0;
    if (d_r && d_inflight && $urandom_range(0, 39) == 0) d_r = 1'b0;
  endtask

  // One clock cycle: requester drops, new stimulus, memory returns, pin drive, model decision.
  task automatic step();
    mem_t e;
    st_t  s;
    @(posedge clk);
    #1;
    cyc++;
    if (i_inflight && cyc == i_drop_at) begin i_r = 1'b0; i_inflight = 1'b0; end
    if (d_inflight && cyc == d_drop_at) begin d_r = 1'b0; d_inflight = 1'b0; end
    if (st_r && st_ack_at == cyc - 1) st_r = 1'b0;
    if (rnd_en && !rst_r) random_stim();
    mem_valid = 1'b0;
    mem_rdata = '0;
    while (mem_q.size() > 0 && mem_q[0].due < cyc) void'(mem_q.pop_front());
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      e         = mem_q.pop_front();
      mem_valid = 1'b1;
      mem_rdata = mem_fn(e.addr);
    end
    rst_n       = !rst_r;
    i_miss      = i_r;
    i_miss_addr = i_a;
    d_miss      = d_r;
    d_miss_addr = d_a;
    st_req      = st_r;
    st_addr     = s_a;
    st_data     = s_d;
    if (rst_r) begin
      exp_rd_q.delete();
      exp_fill_q.delete();
      exp_done_q.delete();
      exp_st_q.delete();
      i_inflight = 1'b0;
      d_inflight = 1'b0;
      busy_lo    = -1;
      busy_hi    = -2;
      free_at    = cyc + 1;
    end else if (cyc >= free_at) begin
      if (st_r) begin
        s.cyc  = cyc;
        s.addr = s_a;
        s.data = s_d;
        exp_st_q.push_back(s);
        st_ack_at = cyc;
      end else if (d_r) begin
        grant(1'b1, d_a);
      end else if (i_r) begin
        grant(1'b0, i_a);
      end
    end
  endtask

  // Memory: every read issued in cycle n returns in cycle n + MEM_LAT, regardless of arbiter reset.
  always @(negedge clk) begin
    mem_t m;
    if (mem_en === 1'b1 && mem_wr === 1'b0) begin
      m.due  = cyc + MEM_LAT;
      m.addr = mem_addr;
      mem_q.push_back(m);
    end
  end

  // Monitor: pop and compare whenever the DUT presents an event; flag overdue expectations.
  always @(negedge clk) begin
    rd_t   r;
    fill_t f;
    done_t d;
    st_t   s;
    if (!rst_n) begin
      check("reset_outputs",
            {st_ack, mem_en, mem_wr, mem_addr, mem_wdata, i_fill_wen, d_fill_wen, fill_word,
             fill_data, i_tag_wen, d_tag_wen, i_fill_done, d_fill_done, busy}, 64'd0);
    end else begin
      while (exp_rd_q.size() > 0 && exp_rd_q[0].cyc < cyc) begin
        note_fail("read_missing", "nothing", $sformatf("read at cycle %0d", exp_rd_q[0].cyc));
        void'(exp_rd_q.pop_front());
      end
      while (exp_fill_q.size() > 0 && exp_fill_q[0].cyc < cyc) begin
        note_fail("fill_missing", "nothing", $sformatf("fill at cycle %0d", exp_fill_q[0].cyc));
        void'(exp_fill_q.pop_front());
      end
      while (exp_done_q.size() > 0 && exp_done_q[0].cyc < cyc) begin
        note_fail("done_missing", "nothing", $sformatf("done at cycle %0d", exp_done_q[0].cyc));
        void'(exp_done_q.pop_front());
      end
      while (exp_st_q.size() > 0 && exp_st_q[0].cyc < cyc) begin
        note_fail("store_missing", "nothing", $sformatf("store ack at cycle %0d", exp_st_q[0].cyc));
        void'(exp_st_q.pop_front());
      end

      if (mem_en && !mem_wr) begin
        if (exp_rd_q.size() == 0) begin
          note_fail("read_unexpected", $sformatf("read of %0h", mem_addr), "no read");
        end else begin
          r = exp_rd_q.pop_front();
          check("read_cycle", 64'(cyc), 64'(r.cyc));
          check("read_addr", 64'(mem_addr), 64'(r.addr));
        end
      end

      if (st_ack || mem_wr) begin
        if (exp_st_q.size() == 0) begin
          note_fail("store_unexpected", $sformatf("st_ack=%0b mem_wr=%0b", st_ack, mem_wr), "no store");
        end else begin
          s = exp_st_q.pop_front();
          check("store_cycle", 64'(cyc), 64'(s.cyc));
          check("store_ctl", 64'({st_ack, mem_en, mem_wr}), 64'(3'b111));
          check("store_addr", 64'(mem_addr), 64'(s.addr));
          check("store_data", 64'(mem_wdata), 64'(s.data));
        end
      end

      if (i_fill_wen || d_fill_wen) begin
        if (exp_fill_q.size() == 0) begin
          note_fail("fill_unexpected", $sformatf("i_wen=%0b d_wen=%0b", i_fill_wen, d_fill_wen), "no fill");
        end else begin
          f = exp_fill_q.pop_front();
          check("fill_cycle", 64'(cyc), 64'(f.cyc));
          check("fill_owner", 64'({d_fill_wen, i_fill_wen}), f.is_d ? 64'd2 : 64'd1);
          check("fill_word", 64'(fill_word), 64'(f.word));
          check("fill_data", 64'(fill_data), 64'(f.data));
        end
      end

      if (i_tag_wen || d_tag_wen || i_fill_done || d_fill_done) begin
        if (exp_done_q.size() == 0) begin
          note_fail("done_unexpected",
                    $sformatf("pulses=%b", {i_tag_wen, i_fill_done, d_tag_wen, d_fill_done}), "none");
        end else begin
          d = exp_done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(d.cyc));
          check("done_pulse", 64'({i_tag_wen, i_fill_done, d_tag_wen, d_fill_done}),
                d.is_d ? 64'h3 : 64'hC);
        end
      end

      check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  initial begin
    rst_n = 1'b0;  i_miss = 1'b0; d_miss = 1'b0; st_req = 1'b0; mem_valid = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; st_addr = '0; st_data = '0; mem_rdata = '0;
    i_r = 1'b0; d_r = 1'b0; st_r = 1'b0; rnd_en = 1'b0; rst_r = 1'b1;
    i_a = '0; d_a = '0; s_a = '0; s_d = '0;
    i_inflight = 1'b0; d_inflight = 1'b0;

    repeat (3) step();
    rst_r = 1'b0;
    repeat (2) step();

    // Lone I miss: block 0x1230.
    i_r = 1'b1; i_a = 16'h1234;
    repeat (16) step();

    // Simultaneous I and D misses: D first, I right after.
    i_r = 1'b1; i_a = 16'h0040; d_r = 1'b1; d_a = 16'h8006;
    repeat (30) step();

    // Store arriving during an I fill waits until the arbiter is idle.
    i_r = 1'b1; i_a = 16'h3456;
    step();
    st_r = 1'b1; s_a = 16'h2000; s_d = 16'hBEEF;
    repeat (16) step();

    // Store and D miss together: store first, then the D grant.
    st_r = 1'b1; s_a = 16'h2002; s_d = 16'h1357; d_r = 1'b1; d_a = 16'h4444;
    repeat (17) step();

    // I miss flushed three cycles into the fill: the fill still completes.
    i_r = 1'b1; i_a = 16'h5678;
    repeat (3) step();
    i_r = 1'b0;
    repeat (14) step();

    // Reset seven cycles into a D fill while read data keeps returning.
    d_r = 1'b1; d_a = 16'h7ABC;
    repeat (7) step();
    rst_r = 1'b1; i_r = 1'b0; d_r = 1'b0; st_r = 1'b0;
    repeat (2) step();
    rst_r = 1'b0;
    repeat (8) step();
    i_r = 1'b1; i_a = 16'h9990;
    repeat (16) step();

    // Random traffic with flushes.
    rnd_en = 1'b1;
    repeat (1500) step();
    rnd_en = 1'b0;
    repeat (60) step();

    foreach (exp_rd_q[k])   note_fail("read_leftover", "nothing", $sformatf("read at cycle %0d", exp_rd_q[k].cyc));
    foreach (exp_fill_q[k]) note_fail("fill_leftover", "nothing", $sformatf("fill at cycle %0d", exp_fill_q[k].cyc));
    foreach (exp_done_q[k]) note_fail("done_leftover", "nothing", $sformatf("done at cycle %0d", exp_done_q[k].cyc));
    foreach (exp_st_q[k])   note_fail("store_leftover", "nothing", $sformatf("store at cycle %0d", exp_st_q[k].cyc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
